acc_requant_u8: RTL

- Downstream stage for the 20-bit unsigned integer accumulator in the vector ALU.
- Accepts finished accumulator values over a valid/ready handshake.
- Applies a programmable right shift with round-half-up, then saturates to an unsigned 8-bit result.
- Two-stage stallable pipeline that also keeps a saturating count of clipped results for debug/calibration.

---
 rtl/acc_requant_u8_if.sv | 29 ++
 rtl/acc_requant_u8.sv | 83 ++++++++
 2 files changed

// File: rtl/acc_requant_u8_if.sv
// Handshake bundle for the accumulator requantizer: input stream, output stream and
// the saturation-count debug port.
interface acc_requant_u8_if #(
    parameter int unsigned IN_W    = 20,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned SHIFT_W = 5,
    parameter int unsigned CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic [SHIFT_W-1:0] in_shift;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_sat;
    logic               sat_clr;
    logic [CNT_W-1:0]   sat_count;

    modport master (
        output in_valid, in_data, in_shift, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, out_sat, sat_count
    );

    modport slave (
        input  in_valid, in_data, in_shift, out_ready, sat_clr,
        output in_ready, out_valid, out_data, out_sat, sat_count
    );
endinterface

// File: rtl/acc_requant_u8.sv
// Two-stage stallable requantizer: rounding right shift of an unsigned accumulator,
// then saturation to OUT_W bits, with a saturating count of clipped outputs.
module acc_requant_u8 #(
    parameter int unsigned IN_W    = 20,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned SHIFT_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    acc_requant_u8_if.slave    bus
);
    localparam int unsigned      R_W     = IN_W + 1;
    localparam logic [R_W-1:0]   R_MAX   = R_W'((2 ** OUT_W) - 1);
    localparam logic [OUT_W-1:0] OUT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               s1_valid;
    logic [R_W-1:0]     s1_r;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_data_q;
    logic               out_sat_q;
    logic [CNT_W-1:0]   sat_count_q;

    logic               out_go_c;
    logic               s1_go_c;
    logic               s1_sat_c;
    logic [R_W-1:0]     trunc_c;
    logic [R_W-1:0]     r_c;

    // Round-half-up: shift by one less, add one, drop the last bit.
    always_comb begin
        trunc_c = '0;
        r_c     = '0;
        if (bus.in_shift == '0) begin
            r_c = R_W'(bus.in_data);
        end else if (32'(bus.in_shift) <= IN_W) begin
            trunc_c = R_W'(bus.in_data) >> (bus.in_shift - SHIFT_W'(1));
            r_c     = (trunc_c + R_W'(1)) >> 1;
        end
    end

    assign out_go_c = ~out_valid_q | bus.out_ready;
    assign s1_go_c  = ~s1_valid | out_go_c;
    assign s1_sat_c = (s1_r > R_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_r        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            if (out_go_c) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    out_data_q <= s1_sat_c ? OUT_MAX : s1_r[OUT_W-1:0];
                    out_sat_q  <= s1_sat_c;
                end
            end
            if (s1_go_c) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_r <= r_c;
                end
            end
            // Clear wins over a same-cycle clipped transfer.
            if (bus.sat_clr) begin
                sat_count_q <= '0;
            end else if (out_valid_q && bus.out_ready && out_sat_q && (sat_count_q != CNT_MAX)) begin
                sat_count_q <= sat_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = s1_go_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.sat_count = sat_count_q;
endmodule
